// File: rtl/res_mem_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | res_mem_arbiter_if : requester and result-memory signals of the arbiter  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface res_mem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [13:0] m0_addr;
  logic [7:0]  m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;

  logic        m1_req;
  logic        m1_we;
  logic [13:0] m1_addr;
  logic [7:0]  m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;

  logic [7:0]  rdata;

  logic        res_rd;
  logic        res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do;
  logic [7:0]  res_di;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    output res_rd, res_wr, res_addr, res_do,
    input  res_di
  );

  // Requester and memory side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    input  res_rd, res_wr, res_addr, res_do,
    output res_di
  );
endinterface

`default_nettype wire

// File: rtl/res_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | res_mem_arbiter : round-robin, burst-bounded arbiter for the 16Kx8       |
// | result memory. Optional grant counters under RES_ARB_STATS_EN.           |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module res_mem_arbiter #(
  parameter int unsigned MAX_BURST = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  res_mem_arbiter_if.slave  bus,
  input  wire logic         stat_clr,
  output logic [15:0]       stat_gnt0,
  output logic [15:0]       stat_gnt1
);

  localparam logic [7:0] C_MAX_BURST = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  owner_e      owner_q, owner_d;
  logic [7:0]  burst_q, burst_d;
  logic        tag_vld_q, tag_vld_d;
  logic        tag_port_q, tag_port_d;

  logic        gnt0, gnt1;
  logic        burst_lim;
  logic        rvalid0, rvalid1;

  // Above the limit (saturated run with a silent peer) also yields.
  assign burst_lim = (burst_q >= C_MAX_BURST);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (owner_q)
      OWN0: begin
        if (bus.m0_req) begin
          if (bus.m1_req && burst_lim) gnt1 = 1'b1;
          else                         gnt0 = 1'b1;
        end else if (bus.m1_req) begin
          gnt1 = 1'b1;
        end
      end
      OWN1: begin
        if (bus.m1_req) begin
          if (bus.m0_req && burst_lim) gnt0 = 1'b1;
          else                         gnt1 = 1'b1;
        end else if (bus.m0_req) begin
          gnt0 = 1'b1;
        end
      end
      default: begin
        if (bus.m0_req)      gnt0 = 1'b1;
        else if (bus.m1_req) gnt1 = 1'b1;
      end
    endcase
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    bus.res_rd   = 1'b0;
    bus.res_wr   = 1'b0;
    bus.res_addr = 14'd0;
    bus.res_do   = 8'd0;
    if (gnt0) begin
      bus.res_rd   = !bus.m0_we;
      bus.res_wr   = bus.m0_we;
      bus.res_addr = bus.m0_addr;
      bus.res_do   = bus.m0_wdata;
    end else if (gnt1) begin
      bus.res_rd   = !bus.m1_we;
      bus.res_wr   = bus.m1_we;
      bus.res_addr = bus.m1_addr;
      bus.res_do   = bus.m1_wdata;
    end
  end

  always_comb begin
    owner_d    = IDLE;
    burst_d    = 8'd0;
    tag_vld_d  = (gnt0 && !bus.m0_we) || (gnt1 && !bus.m1_we);
    tag_port_d = gnt1;
    if (gnt0) begin
      owner_d = OWN0;
      if (owner_q == OWN0) burst_d = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
      else                 burst_d = 8'd1;
    end else if (gnt1) begin
      owner_d = OWN1;
      if (owner_q == OWN1) burst_d = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
      else                 burst_d = 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q    <= IDLE;
      burst_q    <= 8'd0;
      tag_vld_q  <= 1'b0;
      tag_port_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      tag_vld_q  <= tag_vld_d;
      tag_port_q <= tag_port_d;
    end
  end

  assign rvalid0 = reset && tag_vld_q && !tag_port_q;
  assign rvalid1 = reset && tag_vld_q &&  tag_port_q;

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rvalid0;
  assign bus.m1_rvalid = rvalid1;
  assign bus.rdata     = (rvalid0 || rvalid1) ? bus.res_di : 8'd0;

`ifdef RES_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  // A grant coinciding with the clear is dropped, not counted.
  always_ff @(posedge clk) begin
    if (!reset || stat_clr) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      if (gnt0) cnt0_q <= cnt0_q + 16'd1;
      if (gnt1) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign stat_gnt0 = reset ? cnt0_q : 16'd0;
  assign stat_gnt1 = reset ? cnt1_q : 16'd0;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_gnt0       = 16'd0;
  assign stat_gnt1       = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_res_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_res_mem_arbiter : directed self-checking bench for res_mem_arbiter    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_res_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        stat_clr;
  logic [15:0] stat_gnt0;
  logic [15:0] stat_gnt1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:16383];

  res_mem_arbiter_if bus ();

  res_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .stat_clr  (stat_clr),
    .stat_gnt0 (stat_gnt0),
    .stat_gnt1 (stat_gnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous memory: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.res_wr) mem[bus.res_addr] <= bus.res_do;
    if (bus.res_rd) bus.res_di <= mem[bus.res_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_reqs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 14'd0; bus.m0_wdata = 8'd0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 14'd0; bus.m1_wdata = 8'd0;
  endtask

  logic [15:0] exp_s0, exp_s1;
  logic        e_prev;
  logic        e_cur;
  int          bad;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h0081] = 8'h05;
    mem[14'h0010] = 8'hA0;
    mem[14'h0020] = 8'hB1;
    bus.res_di = 8'h00;
    reset      = 1'b0;
    stat_clr   = 1'b0;
    idle_reqs();

    // Reset asserted with a pending request: everything forced low.
    bus.m0_req  = 1'b1;
    bus.m0_addr = 14'h0081;
    cyc(); cyc();
    check("rst_gnt0", 32'(bus.m0_gnt), 32'd0);
    check("rst_gnt1", 32'(bus.m1_gnt), 32'd0);
    check("rst_rd", 32'(bus.res_rd), 32'd0);
    check("rst_addr", 32'(bus.res_addr), 32'd0);
    check("rst_rvalid0", 32'(bus.m0_rvalid), 32'd0);
    check("rst_stat0", 32'(stat_gnt0), 32'd0);

    // Lone port-0 read of 0x0081.
    reset = 1'b1;
    #1;
    check("rd0_gnt", 32'(bus.m0_gnt), 32'd1);
    check("rd0_gnt1", 32'(bus.m1_gnt), 32'd0);
    check("rd0_res_rd", 32'(bus.res_rd), 32'd1);
    check("rd0_res_wr", 32'(bus.res_wr), 32'd0);
    check("rd0_addr", 32'(bus.res_addr), 32'h0081);
    cyc();
    idle_reqs();
    #1;
    check("rd0_rvalid", 32'(bus.m0_rvalid), 32'd1);
    check("rd0_rdata", 32'(bus.rdata), 32'h05);
    check("rd0_rvalid1", 32'(bus.m1_rvalid), 32'd0);
    check("idle_gnt0", 32'(bus.m0_gnt), 32'd0);
    check("idle_rd", 32'(bus.res_rd), 32'd0);
    cyc();
    #1;
    check("rd0_rvalid_gone", 32'(bus.m0_rvalid), 32'd0);
    check("rdata_zero", 32'(bus.rdata), 32'd0);

    // Port 0 writes 0x7F to 0x3FFF, port 1 reads it back.
    cyc();
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 14'h3FFF; bus.m0_wdata = 8'h7F;
    #1;
    check("wr_gnt", 32'(bus.m0_gnt), 32'd1);
    check("wr_res_wr", 32'(bus.res_wr), 32'd1);
    check("wr_res_rd", 32'(bus.res_rd), 32'd0);
    check("wr_do", 32'(bus.res_do), 32'h7F);
    check("wr_addr", 32'(bus.res_addr), 32'h3FFF);
    cyc();
    idle_reqs();
    bus.m1_req = 1'b1; bus.m1_addr = 14'h3FFF;
    #1;
    check("rd1_gnt", 32'(bus.m1_gnt), 32'd1);
    check("rd1_addr", 32'(bus.res_addr), 32'h3FFF);
    check("wr_no_rvalid", 32'(bus.m0_rvalid), 32'd0);
    cyc();
    idle_reqs();
    #1;
    check("rd1_rvalid", 32'(bus.m1_rvalid), 32'd1);
    check("rd1_rdata", 32'(bus.rdata), 32'h7F);
    check("rd1_rvalid0", 32'(bus.m0_rvalid), 32'd0);

    // Port 1 read granted, then reset drops the in-flight tag.
    cyc();
    bus.m1_req = 1'b1; bus.m1_addr = 14'h0020;
    #1;
    check("rr_gnt1", 32'(bus.m1_gnt), 32'd1);
    cyc();
    idle_reqs();
    reset = 1'b0;
    #1;
    check("rr_forced_rvalid", 32'(bus.m1_rvalid), 32'd0);
    check("rr_forced_rdata", 32'(bus.rdata), 32'd0);
    cyc();
    reset = 1'b1;
    bus.m1_req = 1'b1; bus.m1_addr = 14'h0020;
    #1;
    check("rr_no_rvalid", 32'(bus.m1_rvalid), 32'd0);
    check("rr_regrant", 32'(bus.m1_gnt), 32'd1);
    check("rr_burst_clr", 32'(dut.burst_q), 32'd0);
    cyc();
    idle_reqs();
    #1;
    check("rr_rvalid", 32'(bus.m1_rvalid), 32'd1);
    check("rr_rdata", 32'(bus.rdata), 32'hB1);

    // Continuous contention, MAX_BURST = 4: 0,0,0,0,1,1,1,1,0,0.
    cyc();
    bus.m0_req = 1'b1; bus.m0_addr = 14'h0010;
    bus.m1_req = 1'b1; bus.m1_addr = 14'h0020;
    e_prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      e_cur = (((i / 4) % 2) == 0);
      #1;
      check($sformatf("cont_gnt0_%0d", i), 32'(bus.m0_gnt), 32'(e_cur));
      check($sformatf("cont_gnt1_%0d", i), 32'(bus.m1_gnt), 32'(!e_cur));
      if (i > 0) begin
        check($sformatf("cont_rv0_%0d", i), 32'(bus.m0_rvalid), 32'(e_prev));
        check($sformatf("cont_rv1_%0d", i), 32'(bus.m1_rvalid), 32'(!e_prev));
        check($sformatf("cont_rdata_%0d", i), 32'(bus.rdata), e_prev ? 32'hA0 : 32'hB1);
      end
      e_prev = e_cur;
      cyc();
    end
    idle_reqs();
    #1;
    check("cont_last_rv0", 32'(bus.m0_rvalid), 32'd1);
    check("cont_last_rdata", 32'(bus.rdata), 32'hA0);

    // Grant counters: clear, 10 port-0 grants, 3 port-1 grants.
    cyc();
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    #1;
    check("stat_clr0", 32'(stat_gnt0), 32'd0);
    check("stat_clr1", 32'(stat_gnt1), 32'd0);
    cyc();
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 14'h0100;
    for (int i = 0; i < 10; i++) cyc();
    idle_reqs();
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 14'h0200;
    for (int i = 0; i < 3; i++) cyc();
    idle_reqs();
`ifdef RES_ARB_STATS_EN
    exp_s0 = 16'd10;
    exp_s1 = 16'd3;
`else
    exp_s0 = 16'd0;
    exp_s1 = 16'd0;
`endif
    #1;
    check("stat_gnt0", 32'(stat_gnt0), 32'(exp_s0));
    check("stat_gnt1", 32'(stat_gnt1), 32'(exp_s1));
    cyc();
    stat_clr = 1'b1;
    bus.m0_req = 1'b1; bus.m0_we = 1'b1;
    cyc();
    stat_clr = 1'b0;
    idle_reqs();
    #1;
    check("stat_clr_gnt0", 32'(stat_gnt0), 32'd0);
    check("stat_clr_gnt1", 32'(stat_gnt1), 32'd0);

    // Port 0 alone for 300 cycles: always granted, burst saturates.
    cyc();
    bus.m0_req = 1'b1; bus.m0_addr = 14'h0010;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      n_tests++;
      assert (bus.m0_gnt === 1'b1 && bus.m1_gnt === 1'b0) else begin
        n_fail++;
        bad++;
        if (bad < 4)
          $error("FAIL solo_gnt_%0d: observed gnt0=%0b gnt1=%0b expected gnt0=1 gnt1=0",
                 i, bus.m0_gnt, bus.m1_gnt);
      end
      cyc();
    end
    #1;
    check("solo_burst_sat", 32'(dut.burst_q), 32'd255);
    idle_reqs();
    cyc();
    #1;
    check("solo_burst_idle", 32'(dut.burst_q), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/res_mem_arbiter.md
# res_mem_arbiter

Two-requester arbiter for the single-port 16384x8 result memory. It shares the `res_*` port between the distance-transform engine (port 0) and the host readout/preload engine (port 1). One access is issued per cycle. Ownership is round-robin with a bounded burst, so neither side starves. The block sits between both requesters and the memory pins, and it owns the `res_rd`/`res_wr` strobes exclusively.

## Interface
- `MAX_BURST`, default 16: consecutive grants the owner keeps while the other side is requesting; legal range 1..255.
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, synchronous, active-low.
- `m0_req`, `m1_req` input 1: access request, held until granted.
- `m0_we`, `m1_we` input 1: 1 = write, 0 = read; valid with req.
- `m0_addr`, `m1_addr` input 14: word address; valid with req.
- `m0_wdata`, `m1_wdata` input 8: write data; valid with req.
- `m0_gnt`, `m1_gnt` output 1: access accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid` output 1: read data valid for that port.
- `rdata` output 8: read data, shared by both ports, qualified by `mX_rvalid`.
- `res_rd` output 1: memory read strobe.
- `res_wr` output 1: memory write strobe.
- `res_addr` output 14: memory address.
- `res_do` output 8: memory write data.
- `res_di` input 8: memory read data; valid the cycle after `res_rd`.
- `stat_gnt0`, `stat_gnt1` output 16: grant counters; only present with the feature macro.
- `stat_clr` input 1: counter clear.

## Operation
- Arbitration state is held in two registers:
  - `owner`, one of IDLE, OWN0, OWN1; reset value IDLE.
  - `burst`, 8 bits; reset value 0.
- Grant decision is combinational from the requests and the state:
  - IDLE: `m0_req` wins; otherwise `m1_req`.
  - OWNx with `mx_req` high:
    - Other side idle: x is granted.
    - Other side requesting and `burst < MAX_BURST`: x is granted.
    - Other side requesting and `burst == MAX_BURST`: the other side is granted.
  - OWNx with `mx_req` low: the other side is granted if it requests.
- Exactly one `gnt` may be high in any cycle; both low when there is no request.
- Granted access drives the memory port in the same cycle:
  - `res_addr` = `mX_addr`.
  - `res_do` = `mX_wdata`.
  - `res_wr` = `mX_we`.
  - `res_rd` = !`mX_we`.
- With no grant: `res_rd` = `res_wr` = 0, `res_addr` = 0, `res_do` = 0.
- State update each clock:
  - Grant to x: `owner` becomes OWNx. `burst` increments (saturating at 255) if x was already owner; otherwise it loads 1.
  - No grant: `owner` becomes IDLE and `burst` becomes 0.
- Read return path:
  - A registered `rd_tag` (valid + port) captures granted reads.
  - The next cycle `mX_rvalid` = 1 for the tagged port only.
  - `rdata` = `res_di`, passed through combinationally; 0 when neither rvalid is high.
- Writes produce no rvalid.
- Back-to-back reads from alternating ports return in issue order, one per cycle.

## Timing
- Grant latency: 0 cycles; the access is on the memory pins in the cycle `gnt` is high.
- Read latency: rvalid/rdata appear 1 cycle after grant. Throughput is 1 access per cycle.
- Requester rule: keep req/we/addr/wdata stable until `gnt`; change or drop them the cycle after.
- Reset:
  - While `reset` is low, all outputs are forced 0 combinationally, including `gnt`, strobes and rvalid.
  - Every register clears at the clock edge that samples `reset` low.
  - An in-flight read tag is discarded, so no rvalid follows reset release.
- Simultaneous first requests from IDLE: port 0 is granted.
- `MAX_BURST` = 1 gives strict alternation under continuous contention.
- Burst saturation at 255 only matters when the other port is silent, and it is harmless there.

## Configuration
- `RES_ARB_STATS_EN` defined:
  - Two 16-bit counters count grants per port, wrapping at 65535→0.
  - `stat_clr` zeroes both counters synchronously; a grant in the same cycle as `stat_clr` is not counted.
  - Counters reset to 0.
- `RES_ARB_STATS_EN` undefined: counters are not built, `stat_gnt0`/`stat_gnt1` are tied to 0, and `stat_clr` is ignored.

## Test plan
- Port 0 reads 0x0081 alone, memory holds 0x05 there → `m0_gnt` in cycle 0, `res_rd`=1, `res_addr`=0x0081; `m0_rvalid`=1 and `rdata`=0x05 in cycle 1; `m1_rvalid` stays 0.
- Both ports request continuously with `MAX_BURST`=4 → grant sequence 0,0,0,0,1,1,1,1,0,… and never both grants in one cycle.
- Port 0 writes 0x7F to 0x3FFF, then port 1 reads 0x3FFF → `res_wr`=1 with `res_do`=0x7F; then `m1_rvalid`=1 with `rdata`=0x7F.
- Port 1 read granted, then `reset` is driven low the next cycle → `m1_rvalid`=0, `owner`=IDLE; after release, port 1's first request is granted in 0 cycles.
- Port 0 only, for 300 cycles → every cycle granted, `burst` saturates at 255, and `m1_gnt` never asserts.
- With `RES_ARB_STATS_EN`: 10 port-0 grants and 3 port-1 grants → `stat_gnt0`=10, `stat_gnt1`=3. Pulse `stat_clr` → both 0. Without the macro both read 0 throughout.
